// File: rtl/cnn_pkg.sv
// Shared widths, activation limits and types for the CNN post-accumulation datapath.
package cnn_pkg;
  localparam int DIN_W   = 18;
  localparam int BIAS_W  = 18;
  localparam int DOUT_W  = 8;
  localparam int ACT_MAX = (1 << (DOUT_W - 1)) - 1;

  typedef logic signed [DIN_W-1:0]  acc_t;
  typedef logic signed [DOUT_W-1:0] act_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction
endpackage

// File: rtl/maxpool2x2_line.sv
// 2x2 stride-2 max pooling over a raster-ordered activation stream using a half-width line buffer.
// Only instantiated when ACCU_MAXPOOL_EN is defined.
module maxpool2x2_line
  import cnn_pkg::*;
#(
  parameter int FMAP_W = 26,
  parameter int FMAP_H = 26,
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  act_t             din,
  input  logic             sat_in,
  input  logic [COL_W-1:0] col_in,
  input  logic [ROW_W-1:0] row_in,
  output logic             valid_out,
  output act_t             dout,
  output logic             sat_flag,
  output logic [COL_W-1:0] col_out,
  output logic [ROW_W-1:0] row_out,
  output logic             frame_done
);
  localparam int LINE_N = FMAP_W / 2;
  localparam logic [COL_W-2:0] PCOL_LAST = (COL_W-1)'(FMAP_W / 2 - 1);
  localparam logic [ROW_W-2:0] PROW_LAST = (ROW_W-1)'(FMAP_H / 2 - 1);

  act_t             line_mem [LINE_N];
  logic             line_sat [LINE_N];
  act_t             held;
  logic             held_sat;
  act_t             pair_max;
  act_t             win_max;
  logic [COL_W-2:0] pcol;
  logic [ROW_W-2:0] prow;

  assign pcol = col_in[COL_W-1:1];
  assign prow = row_in[ROW_W-1:1];

  always_comb begin
    pair_max = (din > held) ? din : held;
    win_max  = (line_mem[pcol] > pair_max) ? line_mem[pcol] : pair_max;
  end

  // Even columns park in 'held'; odd columns either fill the line buffer (even row) or close the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_N; i++) begin
        line_mem[i] <= '0;
        line_sat[i] <= 1'b0;
      end
      held       <= '0;
      held_sat   <= 1'b0;
      valid_out  <= 1'b0;
      dout       <= '0;
      sat_flag   <= 1'b0;
      col_out    <= '0;
      row_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col_in[0]) begin
          held     <= din;
          held_sat <= sat_in;
        end else if (!row_in[0]) begin
          line_mem[pcol] <= pair_max;
          line_sat[pcol] <= held_sat | sat_in;
        end else begin
          valid_out  <= 1'b1;
          dout       <= win_max;
          sat_flag   <= line_sat[pcol] | held_sat | sat_in;
          col_out    <= {1'b0, pcol};
          row_out    <= {1'b0, prow};
          frame_done <= (pcol == PCOL_LAST) && (prow == PROW_LAST);
        end
      end
    end
  end
endmodule

// File: rtl/accu_bias_relu_quant.sv
// Bias add, ReLU, round-half-up right shift and saturation of accumulated conv sums, with pixel tracking.
// Define ACCU_MAXPOOL_EN to append 2x2 stride-2 max pooling on the quantized stream.
module accu_bias_relu_quant
  import cnn_pkg::*;
#(
  parameter  int FMAP_W  = 26,
  parameter  int FMAP_H  = 26,
  parameter  int SHIFT_W = 4,
  localparam int COL_W   = clog2(FMAP_W),
  localparam int ROW_W   = clog2(FMAP_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DIN_W-1:0]  din,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  output logic                     valid_out,
  output logic [DOUT_W-1:0]        dout,
  output logic [COL_W-1:0]         col_out,
  output logic [ROW_W-1:0]         row_out,
  output logic                     frame_done,
  output logic                     sat_flag
);
  localparam int SUM_W = DIN_W + 1;
  localparam int Q_W   = DIN_W + 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  logic [COL_W-1:0]        col_cnt;
  logic [ROW_W-1:0]        row_cnt;

  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [COL_W-1:0]        s1_col;
  logic [ROW_W-1:0]        s1_row;

  logic                    s2_valid;
  logic [Q_W-1:0]          s2_q;
  logic [COL_W-1:0]        s2_col;
  logic [ROW_W-1:0]        s2_row;

  logic                    s3_valid;
  act_t                    s3_act;
  logic                    s3_sat;
  logic                    s3_done;
  logic [COL_W-1:0]        s3_col;
  logic [ROW_W-1:0]        s3_row;

  logic [Q_W-1:0]          relu_v;
  logic [Q_W-1:0]          round_v;
  logic [Q_W-1:0]          quant_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (valid_in) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // One extra bit on the sum keeps extreme din+bias from wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_sum <= SUM_W'(din) + SUM_W'(bias);
        s1_col <= col_cnt;
        s1_row <= row_cnt;
      end
    end
  end

  always_comb begin
    relu_v  = s1_sum[SUM_W-1] ? '0 : Q_W'(s1_sum);
    round_v = (cfg_shift == '0) ? '0 : (Q_W'(1) << (cfg_shift - SHIFT_W'(1)));
    quant_v = (relu_v + round_v) >> cfg_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_col   <= '0;
      s2_row   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q   <= quant_v;
        s2_col <= s1_col;
        s2_row <= s1_row;
      end
    end
  end

  // Output stage holds its data between valid beats; only valid and frame_done drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_act   <= '0;
      s3_sat   <= 1'b0;
      s3_done  <= 1'b0;
      s3_col   <= '0;
      s3_row   <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_done  <= s2_valid && (s2_col == COL_LAST) && (s2_row == ROW_LAST);
      if (s2_valid) begin
        s3_col <= s2_col;
        s3_row <= s2_row;
        if (s2_q > Q_W'(ACT_MAX)) begin
          s3_act <= act_t'(ACT_MAX);
          s3_sat <= 1'b1;
        end else begin
          s3_act <= s2_q[DOUT_W-1:0];
          s3_sat <= 1'b0;
        end
      end
    end
  end

`ifdef ACCU_MAXPOOL_EN
  maxpool2x2_line #(
    .FMAP_W (FMAP_W),
    .FMAP_H (FMAP_H),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_pool (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (s3_valid),
    .din        (s3_act),
    .sat_in     (s3_sat),
    .col_in     (s3_col),
    .row_in     (s3_row),
    .valid_out  (valid_out),
    .dout       (dout),
    .sat_flag   (sat_flag),
    .col_out    (col_out),
    .row_out    (row_out),
    .frame_done (frame_done)
  );
`else
  assign valid_out  = s3_valid;
  assign dout       = s3_act;
  assign sat_flag   = s3_sat;
  assign col_out    = s3_col;
  assign row_out    = s3_row;
  assign frame_done = s3_done;
`endif
endmodule

// File: tb/tb_accu_bias_relu_quant.sv
// Directed bench for accu_bias_relu_quant (default build, pooling disabled).
module tb_accu_bias_relu_quant;
  import cnn_pkg::*;

  localparam int FW   = 26;
  localparam int FH   = 26;
  localparam int NPIX = FW * FH;

  typedef struct { int b; int sh; int d; int q; bit s; } vec_t;
  typedef struct { int q; bit s; int c; int r; bit f; } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     valid_in = 1'b0;
  logic signed [DIN_W-1:0]  din = '0;
  logic signed [BIAS_W-1:0] bias = '0;
  logic [3:0]               cfg_shift = '0;
  logic                     valid_out;
  logic [DOUT_W-1:0]        dout;
  logic [4:0]               col_out;
  logic [4:0]               row_out;
  logic                     frame_done;
  logic                     sat_flag;

  int   checks = 0;
  int   errors = 0;
  int   pix = 0;
  exp_t exp_q[$];

  // bias, shift, din -> dout, sat (hand computed)
  vec_t vecs [13] = '{
    '{0, 0, 5, 5, 1'b0},
    '{0, 0, -7, 0, 1'b0},
    '{0, 0, 300, 127, 1'b1},
    '{0, 4, 23, 1, 1'b0},
    '{0, 4, 24, 2, 1'b0},
    '{120, 4, -100, 1, 1'b0},
    '{131071, 0, 131071, 127, 1'b1},
    '{-131072, 0, -131072, 0, 1'b0},
    '{-131072, 0, -1, 0, 1'b0},
    '{0, 15, 131071, 4, 1'b0},
    '{0, 2, -3, 0, 1'b0},
    '{0, 1, 253, 127, 1'b0},
    '{0, 1, 255, 127, 1'b1}
  };

  always #5 clk = ~clk;

  accu_bias_relu_quant dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .din        (din),
    .bias       (bias),
    .cfg_shift  (cfg_shift),
    .valid_out  (valid_out),
    .dout       (dout),
    .col_out    (col_out),
    .row_out    (row_out),
    .frame_done (frame_done),
    .sat_flag   (sat_flag)
  );

  function automatic exp_t model(input int v, input int b, input int sh, input int p);
    exp_t e;
    int   s;
    s = v + b;
    if (s < 0) s = 0;
    if (sh > 0) s = s + (1 << (sh - 1));
    s = s >> sh;
    e.q = (s > 127) ? 127 : s;
    e.s = (s > 127);
    e.c = p % FW;
    e.r = (p / FW) % FH;
    e.f = (e.c == FW - 1) && (e.r == FH - 1);
    return e;
  endfunction

  task automatic tick(input logic v, input int d);
    valid_in = v;
    din      = DIN_W'(d);
    @(posedge clk);
    #1;
    if (v) pix++;
  endtask

  task automatic apply_reset;
    valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix = 0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_out, dout, col_out, row_out, frame_done, sat_flag} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%0d c=%0d r=%0d f=%b s=%b expected all 0",
               valid_out, dout, col_out, row_out, frame_done, sat_flag);
    end
    rst = 1'b0;
    tick(1'b0, 0);
    checks++;
    if ({valid_out, dout, col_out, row_out, frame_done, sat_flag} !== '0) begin
      errors++;
      $display("FAIL reset_release got v=%b d=%0d c=%0d r=%0d f=%b s=%b expected all 0",
               valid_out, dout, col_out, row_out, frame_done, sat_flag);
    end
  endtask

  task automatic test_quant;
    int p;
    for (int k = 0; k < 13; k++) begin
      bias      = BIAS_W'(vecs[k].b);
      cfg_shift = 4'(vecs[k].sh);
      p = pix;
      tick(1'b1, vecs[k].d);
      tick(1'b0, 0);
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL quant_latency[%0d] valid_out=%b expected 0", k, valid_out);
      end
      tick(1'b0, 0);
      checks++;
      if ({valid_out, dout, sat_flag, col_out, row_out, frame_done} !==
          {1'b1, 8'(vecs[k].q), vecs[k].s, 5'(p % FW), 5'((p / FW) % FH), 1'b0}) begin
        errors++;
        $display("FAIL quant[%0d] got v=%b d=%0d s=%b c=%0d r=%0d f=%b expected v=1 d=%0d s=%b c=%0d r=%0d f=0",
                 k, valid_out, dout, sat_flag, col_out, row_out, frame_done,
                 vecs[k].q, vecs[k].s, p % FW, (p / FW) % FH);
      end
    end
    tick(1'b0, 0);
    tick(1'b0, 0);
    checks++;
    if ({valid_out, frame_done, dout, sat_flag} !== {1'b0, 1'b0, 8'd127, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold got v=%b f=%b d=%0d s=%b expected v=0 f=0 d=127 s=1",
               valid_out, frame_done, dout, sat_flag);
    end
  endtask

  task automatic test_reset_midstream;
    apply_reset;
    bias      = '0;
    cfg_shift = '0;
    for (int i = 0; i < 2 * FW + 13; i++) tick(1'b1, i + 1);
    valid_in = 1'b1;
    din      = DIN_W'(2 * FW + 14);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid_out, dout, col_out, row_out, frame_done, sat_flag} !== '0) begin
      errors++;
      $display("FAIL midstream_reset got v=%b d=%0d c=%0d r=%0d f=%b s=%b expected all 0",
               valid_out, dout, col_out, row_out, frame_done, sat_flag);
    end
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix = 0;
    tick(1'b1, 9);
    tick(1'b0, 0);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL midstream_flush valid_out=%b expected 0", valid_out);
    end
    tick(1'b0, 0);
    checks++;
    if ({valid_out, dout, col_out, row_out, frame_done} !== {1'b1, 8'd9, 5'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL midstream_first got v=%b d=%0d c=%0d r=%0d f=%b expected v=1 d=9 c=0 r=0 f=0",
               valid_out, dout, col_out, row_out, frame_done);
    end
  endtask

  task automatic test_stream(input bit gapped, input int npix);
    int   sent = 0;
    int   tail = 0;
    int   outs = 0;
    int   dones = 0;
    int   v;
    bit   go;
    exp_t e;
    apply_reset;
    bias      = BIAS_W'(10);
    cfg_shift = '0;
    for (int cyc = 0; cyc < 6 * npix + 50; cyc++) begin
      go = (sent < npix) && (!gapped || ($urandom_range(0, 2) != 0));
      if (go) begin
        v = (sent % 120) + 1;
        exp_q.push_back(model(v, 10, 0, pix));
        tick(1'b1, v);
        sent++;
      end else begin
        tick(1'b0, 0);
        if (sent >= npix) tail++;
      end
      if (valid_out === 1'b1) begin
        outs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra gapped=%0d got d=%0d c=%0d r=%0d expected no output",
                   gapped, dout, col_out, row_out);
        end else begin
          e = exp_q.pop_front();
          if ({dout, sat_flag, col_out, row_out, frame_done} !==
              {8'(e.q), e.s, 5'(e.c), 5'(e.r), e.f}) begin
            errors++;
            $display("FAIL stream gapped=%0d got d=%0d s=%b c=%0d r=%0d f=%b expected d=%0d s=%b c=%0d r=%0d f=%b",
                     gapped, dout, sat_flag, col_out, row_out, frame_done, e.q, e.s, e.c, e.r, e.f);
          end
          if (frame_done === 1'b1) dones++;
        end
      end else begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++;
          $display("FAIL stream_idle_done gapped=%0d frame_done=%b expected 0", gapped, frame_done);
        end
      end
      if (tail >= 4) break;
    end
    checks++;
    if (outs != npix || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count gapped=%0d got %0d outputs (%0d pending) expected %0d",
               gapped, outs, exp_q.size(), npix);
    end
    checks++;
    if (dones != npix / NPIX) begin
      errors++;
      $display("FAIL stream_frames gapped=%0d got %0d frame_done expected %0d", gapped, dones, npix / NPIX);
    end
  endtask

  initial begin
    test_reset;
    test_quant;
    test_reset_midstream;
    test_stream(1'b0, 2 * NPIX);
    test_stream(1'b1, NPIX + 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accu_bias_relu_quant.md
Name: accu_bias_relu_quant

Overview:
- Post-accumulation stage directly downstream of the accumulating FIFO.
- Consumes final 18-bit signed partial sums, one per cycle, from that FIFO's `valid_out`/`dout`.
- Per sum: adds a per-output-channel bias, applies ReLU, right-shifts with round-half-up, and saturates to 8-bit signed activations for the next conv layer.
- Tracks row/column position within the feature map and flags frame end.

Parameters:
- DIN_W, 18: accumulated sum width (signed).
- BIAS_W, 18: bias width (signed).
- DOUT_W, 8: activation width (signed; output range 0..2^(DOUT_W-1)-1).
- FMAP_W, 26: feature-map width in pixels.
- FMAP_H, 26: feature-map height in pixels.
- SHIFT_W, 4: width of the shift config field.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- valid_in, in, 1: din valid (from accu FIFO valid_out).
- din, in, DIN_W: signed accumulated sum.
- bias, in, BIAS_W: signed bias for the current output channel; stable for the whole frame.
- cfg_shift, in, SHIFT_W: right-shift amount, 0..15; stable for the whole frame.
- valid_out, out, 1: dout valid.
- dout, out, DOUT_W: quantized activation.
- col_out, out, clog2(FMAP_W): column of dout.
- row_out, out, clog2(FMAP_H): row of dout.
- frame_done, out, 1: one-cycle pulse coincident with the last pixel of the frame.
- sat_flag, out, 1: high with valid_out when dout was clipped to max.

Behaviour:
- Reset: all pipeline registers, counters and outputs go to 0 immediately. An in-flight frame is discarded; the next valid_in is pixel (0,0).
- No backpressure. Every valid_in=1 cycle is accepted. Gaps (valid_in=0) are allowed anywhere; the pipeline stages carry their own valid bits.
- Stage 1 (S1): sum = din + bias, computed at DIN_W+1 bits (both sign-extended; cannot overflow).
- Stage 2 (S2): ReLU, so r = (sum<0) ? 0 : sum. Then q = (r + (cfg_shift==0 ? 0 : 1<<(cfg_shift-1))) >>> cfg_shift, computed at DIN_W+2 bits.
- Stage 3 (S3): if q > 2^(DOUT_W-1)-1 (127), then dout=127 and sat_flag=1; else dout=q[DOUT_W-1:0] and sat_flag=0.
- Latency: exactly 3 cycles from valid_in to valid_out.
- Position counters:
  - Advance on each accepted input; col wraps at FMAP_W-1, row increments at col wrap, and row wraps at FMAP_H-1 to 0.
  - Position is captured at input and pipelined alongside the data, so col_out/row_out align with dout.
- frame_done=1 exactly when valid_out=1 and (row_out,col_out)=(FMAP_H-1,FMAP_W-1). The counters are already at (0,0) for the next frame, so back-to-back frames with no idle cycle are supported.
- When valid_out=0, dout/col_out/row_out/sat_flag hold their last values and frame_done=0.

Optional Feature:
- Macro `ACCU_MAXPOOL_EN` adds 2x2 stride-2 max pooling after S3 (FMAP_W and FMAP_H must be even).
  - Line buffer: FMAP_W/2 entries x DOUT_W.
  - Even row: max of (even col, odd col) is written to entry col/2.
  - Odd row, even col: hold the pixel in a register.
  - Odd row, odd col: output max(buffer[col/2], held, current).
  - valid_out fires once per 2x2 window; col_out/row_out are the pooled coordinates (col/2, row/2); latency is 4 cycles from the window's last input.
  - frame_done fires on pooled pixel (FMAP_H/2-1, FMAP_W/2-1).
  - sat_flag is the OR over the window.
- Without the macro, no pooling logic is synthesized and behaviour is exactly as above.

Decomposition:
- Shared package `cnn_pkg`:
  - constants DIN_W, BIAS_W, DOUT_W;
  - ACT_MAX = 2^(DOUT_W-1)-1;
  - clog2 helper function;
  - typedefs acc_t (signed DIN_W) and act_t (signed DOUT_W).
- One sub-module, `maxpool2x2_line`: line buffer plus window compare, instantiated only under `ACCU_MAXPOOL_EN`.

Test Plan:
- Reset mid-stream: assert rst at pixel 13 of row 2 → outputs go to 0 immediately; after release, next valid_out reports (0,0).
- Basic quantization, bias=0, shift=0: din=5 → dout=5 three cycles later; din=-7 → 0; din=300 → 127 with sat_flag=1.
- Rounding, shift=4: din=23, bias=0 → 1; din=24 → 2 (24+8=32, 32>>4=2); din=-100, bias=120 → (20+8)>>4=1.
- Bias at extremes: din=131071, bias=131071 → no wrap, dout=127 with sat_flag; din=-131072, bias=-131072 → 0.
- Full frame of 26x26 ramp inputs (1..120 repeating, mirroring the FIFO bench), valid_in held high, then a second frame back-to-back:
  - exactly 676 valid_out per frame;
  - frame_done on (25,25) only;
  - coordinates correct across the frame boundary.
- Gapped input, valid_in toggling pseudo-randomly → output sequence and coordinates identical to the gapless run. With `ACCU_MAXPOOL_EN`, a 4x4 test map gives 4 pooled outputs equal to the window maxima and frame_done on (1,1).
